// File: rtl/udiv_seq.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Divide-by-zero completes in one cycle with an all-ones quotient and the dz flag set.
module udiv_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] n,
    input  logic [N-1:0]   d,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dz
);

    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [2*N-1:0] dvd, quot, quot_step;
    logic [N-1:0]   dvsr;
    logic [N:0]     pr, pr_sh, pr_step;
    logic [CW-1:0]  cnt;
    logic           accept, ge, last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = (state != RUN) && start;
        last     = (cnt == CW'(2*N-1));
        case (state)
            IDLE, DONE: begin
                if (accept) state_nx = (d == '0) ? DONE : RUN;
                else        state_nx = IDLE;
            end
            RUN: if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        ready = (state != RUN);
        busy  = (state == RUN);
        done  = (state == DONE);
    end

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        pr_sh     = {pr[N-1:0], dvd[2*N-1]};
        ge        = (pr_sh >= {1'b0, dvsr});
        pr_step   = ge ? (pr_sh - {1'b0, dvsr}) : pr_sh;
        quot_step = {quot[2*N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd  <= '0;
            dvsr <= '0;
            pr   <= '0;
            quot <= '0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
            dz   <= 1'b0;
        end else if (accept) begin
            dvd  <= n;
            dvsr <= d;
            pr   <= '0;
            quot <= '0;
            cnt  <= '0;
            // Results are only touched here for the one-cycle divide-by-zero completion.
            if (d == '0) begin
                q  <= '1;
                r  <= '0;
                dz <= 1'b1;
            end
        end else if (state == RUN) begin
            dvd  <= dvd << 1;
            pr   <= pr_step;
            quot <= quot_step;
            cnt  <= cnt + CW'(1);
            if (last) begin
                q  <= quot_step;
                r  <= pr_step[N-1:0];
                dz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_udiv_seq.sv
// Directed and exhaustive checks of udiv_seq (N=4): results, latency, handshake and reset behaviour.
module tb_udiv_seq;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] n;
    logic [3:0] d;
    logic       ready, busy, done, dz;
    logic [7:0] q;
    logic [3:0] r;

    int tests  = 0;
    int failed = 0;

    logic [7:0] last_q;
    logic [3:0] last_r;
    logic       last_dz;

    udiv_seq #(.N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .d(d),
        .ready(ready), .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] n;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT ready; returns at the negedge of the done cycle.
    task automatic run_op(input logic [7:0] nv, input logic [3:0] dv, input logic [7:0] eq,
                          input logic [3:0] er, input logic edz, input bit hold, input bit scramble,
                          input string tag);
        int cyc;
        int bcnt;
        check({tag, " ready_before"}, ready, 1);
        n = nv; d = dv; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (dv != 0) begin
            check({tag, " q_hold"}, q, last_q);
            check({tag, " r_hold"}, r, last_r);
        end
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            if (ready && busy) check({tag, " ready_busy_excl"}, 1, 0);
            if (scramble) begin
                n = 8'($urandom); d = 4'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, (dv == 0) ? 1 : 9);
        check({tag, " busy_cycles"}, bcnt, (dv == 0) ? 0 : 8);
        check({tag, " q"}, q, eq);
        check({tag, " r"}, r, er);
        check({tag, " dz"}, dz, edz);
        check({tag, " ready_at_done"}, ready, 1);
        check({tag, " busy_at_done"}, busy, 0);
        last_q = eq; last_r = er; last_dz = edz;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{n: 8'd200, d: 4'd7,  q: 8'd28,  r: 4'd4, dz: 1'b0};
        vecs[1] = '{n: 8'd255, d: 4'd1,  q: 8'd255, r: 4'd0, dz: 1'b0};
        vecs[2] = '{n: 8'd255, d: 4'd15, q: 8'd17,  r: 4'd0, dz: 1'b0};
        vecs[3] = '{n: 8'd5,   d: 4'd9,  q: 8'd0,   r: 4'd5, dz: 1'b0};
        vecs[4] = '{n: 8'd13,  d: 4'd0,  q: 8'd255, r: 4'd0, dz: 1'b1};
        vecs[5] = '{n: 8'd14,  d: 4'd3,  q: 8'd4,   r: 4'd2, dz: 1'b0};
        vecs[6] = '{n: 8'd0,   d: 4'd5,  q: 8'd0,   r: 4'd0, dz: 1'b0};
        vecs[7] = '{n: 8'd240, d: 4'd15, q: 8'd16,  r: 4'd0, dz: 1'b0};
        vecs[8] = '{n: 8'd1,   d: 4'd15, q: 8'd0,   r: 4'd1, dz: 1'b0};
        vecs[9] = '{n: 8'd0,   d: 4'd0,  q: 8'd255, r: 4'd0, dz: 1'b1};

        rst = 1'b1; start = 1'b0; n = '0; d = '0;
        last_q = '0; last_r = '0; last_dz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset q", q, 0);
        check("reset r", r, 0);
        check("reset dz", dz, 0);

        // Directed table, each op returning to IDLE before the next.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0, 1'b0,
                   $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done_one_cycle", i), done, 0);
            check($sformatf("vec%0d idle_ready", i), ready, 1);
        end

        // Back-to-back with start held, then noise on start/n/d during RUN.
        run_op(8'd200, 4'd7,  8'd28, 4'd4, 1'b0, 1'b1, 1'b0, "b2b0");
        run_op(8'd99,  4'd5,  8'd19, 4'd4, 1'b0, 1'b1, 1'b1, "b2b1");
        run_op(8'd250, 4'd13, 8'd19, 4'd3, 1'b0, 1'b0, 1'b1, "b2b2");
        start = 1'b0;
        @(negedge clk);
        check("b2b idle done", done, 0);
        check("b2b idle ready", ready, 1);
        check("b2b idle busy", busy, 0);

        // Reset in the middle of a division.
        n = 8'd100; d = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst ready", ready, 1);
        check("midrst done", done, 0);
        check("midrst q", q, 0);
        check("midrst r", r, 0);
        check("midrst dz", dz, 0);
        rst = 1'b0;
        last_q = '0; last_r = '0; last_dz = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) check("midrst stray_done", done, 0);
        end
        run_op(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 1'b0, 1'b0, "post_rst");

        // Exhaustive operand sweep, issued back to back.
        for (int ni = 0; ni < 256; ni++) begin
            for (int di = 0; di < 16; di++) begin
                logic [7:0] eq;
                logic [3:0] er;
                eq = (di == 0) ? 8'd255 : 8'(ni / di);
                er = (di == 0) ? 4'd0   : 4'(ni % di);
                run_op(8'(ni), 4'(di), eq, er, (di == 0), 1'b0, 1'b0,
                       $sformatf("sweep n=%0d d=%0d", ni, di));
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("final idle ready", ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/udiv_seq.md
Name: udiv_seq

Overview:
- Sequential unsigned restoring divider; the inverse companion to the team's 4x4 array multiplier.
- Takes a 2N-bit dividend and an N-bit divisor and returns a 2N-bit quotient and an N-bit remainder.
- Produces one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath, so a product can be divided back to recover its operands.

Parameters:
- N, 4, divisor/remainder width. Dividend and quotient are 2N bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled on clk edges only while ready=1
- n  input  2N  dividend; sampled with an accepted start
- d  input  N  divisor; sampled with an accepted start
- ready  output  1  high when a start will be accepted (state IDLE or DONE)
- busy  output  1  high while iterating (state RUN)
- done  output  1  one-cycle pulse; q, r and dz are valid from this cycle onward
- q  output  2N  quotient
- r  output  N  remainder
- dz  output  1  divide-by-zero flag for the last operation

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, busy=0, done=0, q=0, r=0, dz=0, step counter=0. Reset overrides everything, including mid-RUN; a partial result is discarded and q/r return to 0.
- States: IDLE, RUN, DONE.
- Accept: at edge E0 with ready=1 and start=1, register n and d, clear the partial remainder (N+1 bits) and the quotient shift register, and set counter=0.
  - If d≠0: go to RUN.
  - If d=0: go to DONE with q=all ones, r=0, dz=1. done is high in the cycle after E0, so latency is 1.
- RUN, one step per edge (E1..E2N):
  - pr' = {pr[N-1:0], dividend MSB}; shift the dividend left.
  - If pr' ≥ {0,d}: pr=pr'−d and quotient bit=1; else pr=pr' and bit=0.
  - Shift the bit into the quotient LSB and increment the counter.
- At edge E2N (counter reaches 2N): load q from the quotient register, r=pr[N-1:0], dz=0, and go to DONE.
- Latency from accept edge to done-high cycle is 2N+1 cycles, i.e. 9 for N=4.
- DONE lasts exactly one cycle with done=1. At the next edge:
  - If start=1, it is accepted (back-to-back operation) and the new operation begins.
  - Otherwise the state returns to IDLE.
- ready=1 in IDLE and DONE, 0 in RUN. busy=1 only in RUN. ready and busy are never both 1.
- start while busy=1 is ignored. n and d may change freely during RUN without effect.
- q, r and dz hold their values from DONE until the next completion (the next DONE entry) or reset. They do not change at the accept edge.
- Invariant for d≠0: q*d + r == n and r < d. Arithmetic is unsigned throughout, and the partial remainder never overflows N+1 bits.
- done is registered; no output depends combinationally on start, n or d.

Test Plan:
- Reset, then n=200, d=7, start for 1 cycle -> busy for 8 cycles, done pulses 9 cycles after the accept edge; q=28, r=4, dz=0, ready=1 with done.
- n=255, d=1 -> q=255, r=0. Then n=255, d=15 -> q=17, r=0. Then n=5, d=9 -> q=0, r=5.
- n=13, d=0 -> done in the cycle after accept, q=255, r=0, dz=1. A following n=14, d=3 clears dz: q=4, r=2.
- Hold start=1 continuously with new operands presented at each done -> each op accepted in its DONE cycle, 9-cycle throughput per op. Toggling start/n/d during RUN leaves the in-flight result unchanged.
- Assert rst at step 4 of a division -> at the next edge busy=0, ready=1, q=r=dz=0, no done pulse. A new start then completes correctly.
- Random sweep over all 256×16 operand pairs, including d=0 -> q*d+r==n and r<d for d≠0; dz matches (d==0); the done/busy/ready timing rules hold.
